// File: rtl/multi_pulser.sv
// multi_pulser: per-channel one-shot pulse generator with optional typematic auto-repeat.
// Define MULTI_PULSER_REPEAT_EN to enable the hold-delay / repeat-period counter.

module multi_pulser_ch
`ifdef MULTI_PULSER_REPEAT_EN
#(
    parameter int DELAY  = 500,
    parameter int PERIOD = 100,
    parameter int CNT_W  = 9
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse,
    output logic held
);
    typedef enum logic [1:0] {IDLE = 2'd0, FIRE = 2'd1, HOLD = 2'd2} state_t;

    state_t state, state_nxt;

`ifdef MULTI_PULSER_REPEAT_EN
    // FIRE and the zero-count HOLD cycle each take one clock, hence the -2.
    localparam logic [CNT_W-1:0] FIRST_LD = CNT_W'(DELAY - 2);
    localparam logic [CNT_W-1:0] PER_LD   = CNT_W'(PERIOD - 2);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rep, rep_nxt;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
`ifdef MULTI_PULSER_REPEAT_EN
            cnt   <= '0;
            rep   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef MULTI_PULSER_REPEAT_EN
            cnt   <= cnt_nxt;
            rep   <= rep_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = IDLE;
`ifdef MULTI_PULSER_REPEAT_EN
        cnt_nxt   = cnt;
        rep_nxt   = rep;
`endif
        case (state)
            IDLE: begin
                if (din) begin
                    state_nxt = FIRE;
`ifdef MULTI_PULSER_REPEAT_EN
                    rep_nxt   = 1'b0;
`endif
                end
            end
            FIRE: begin
                state_nxt = HOLD;
`ifdef MULTI_PULSER_REPEAT_EN
                cnt_nxt   = rep ? PER_LD : FIRST_LD;
                rep_nxt   = 1'b1;
`endif
            end
            HOLD: begin
`ifdef MULTI_PULSER_REPEAT_EN
                // Release wins over expiry; zero test guards the decrement.
                if (!din) begin
                    state_nxt = IDLE;
                    rep_nxt   = 1'b0;
                end else if (cnt == '0) begin
                    state_nxt = FIRE;
                end else begin
                    state_nxt = HOLD;
                    cnt_nxt   = cnt - 1'b1;
                end
`else
                state_nxt = din ? HOLD : IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pulse = (state == FIRE);
        held  = (state == FIRE) || (state == HOLD);
    end
endmodule

module multi_pulser #(
    parameter int CHANNELS = 4,
    parameter int DELAY    = 500,
    parameter int PERIOD   = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] dataIn,
    output logic [CHANNELS-1:0] dataOut,
    output logic [CHANNELS-1:0] held,
    output logic                anyPulse
);
    if (CHANNELS < 1 || DELAY < 2 || PERIOD < 2) begin : g_bad_cfg
        $error("multi_pulser: CHANNELS>=1, DELAY>=2, PERIOD>=2 required");
    end

`ifdef MULTI_PULSER_REPEAT_EN
    localparam int MAXV  = (DELAY > PERIOD) ? DELAY : PERIOD;
    localparam int CNT_W = $clog2(MAXV);
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        multi_pulser_ch
`ifdef MULTI_PULSER_REPEAT_EN
        #(.DELAY(DELAY), .PERIOD(PERIOD), .CNT_W(CNT_W))
`endif
        u_ch (
            .clock (clock),
            .reset (reset),
            .din   (dataIn[i]),
            .pulse (dataOut[i]),
            .held  (held[i])
        );
    end

    assign anyPulse = |dataOut;
endmodule
